// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous-read RAM port between fetch (read-only) and data (read/write).
// Data accesses win unless fetch has waited STARVE_LIMIT consecutive data grants, which forces fetch through.
// Ports:
//   clk, reset_n (async, active-low)
//   fetch: if_req, if_addr -> if_gnt, if_rvalid, if_rdata, fetch_stall
//   data:  dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb -> dm_gnt, dm_rvalid, dm_rdata
//   ram:   ram_addr, ram_we, ram_wdata, ram_wstrb -> ram_rdata (valid one cycle after the address)
//   perf:  perf_fetch_stall_cycles, perf_forced_fetch (live only with ARB_PERF_CNT_EN, else tied 0)
module mem_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                fetch_stall,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_wstrb,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_we,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic [DATA_W/8-1:0] ram_wstrb,
    input  logic [DATA_W-1:0]   ram_rdata,
    output logic [31:0]         perf_fetch_stall_cycles,
    output logic [31:0]         perf_forced_fetch
);
    typedef enum logic [1:0] {RESP_NONE, RESP_IF, RESP_DM_RD, RESP_DM_WR} resp_t;
    resp_t resp_owner, resp_next;
    logic [3:0] starve_cnt;
    logic forced;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_owner <= RESP_NONE;
            starve_cnt <= '0;
        end else begin
            resp_owner <= resp_next;
            starve_cnt <= (dm_gnt && if_req) ? (starve_cnt == 4'(STARVE_LIMIT) ? starve_cnt : starve_cnt + 4'd1) : '0;
        end
    end
    always_comb begin
        forced      = if_req && dm_req && starve_cnt == 4'(STARVE_LIMIT);
        dm_gnt      = reset_n && dm_req && !forced;
        if_gnt      = reset_n && if_req && !dm_gnt;
        fetch_stall = reset_n && if_req && !if_gnt;
        // an idle cycle still presents the fetch address so the RAM read is already underway
        ram_addr    = !reset_n ? '0 : dm_gnt ? dm_addr : if_addr;
        ram_we      = dm_gnt && dm_we;
        ram_wdata   = dm_gnt ? dm_wdata : '0;
        ram_wstrb   = ram_we ? dm_wstrb : '0;
        resp_next   = dm_gnt ? (dm_we ? RESP_DM_WR : RESP_DM_RD) : if_gnt ? RESP_IF : RESP_NONE;
        if_rvalid   = resp_owner == RESP_IF;
        dm_rvalid   = resp_owner == RESP_DM_RD || resp_owner == RESP_DM_WR;
        if_rdata    = if_rvalid ? ram_rdata : '0;
        dm_rdata    = resp_owner == RESP_DM_RD ? ram_rdata : '0;
    end
`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetch_stall_cycles <= '0;
            perf_forced_fetch       <= '0;
        end else begin
            perf_fetch_stall_cycles <= perf_fetch_stall_cycles + 32'(fetch_stall);
            perf_forced_fetch       <= perf_forced_fetch + 32'(if_gnt && forced);
        end
    end
`else
    assign perf_fetch_stall_cycles = '0;
    assign perf_forced_fetch       = '0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors for mem_port_arbiter against a small byte-strobed RAM model.
module tb_mem_port_arbiter;
    logic        clk = 0;
    logic        reset_n;
    logic        if_req, if_gnt, if_rvalid, fetch_stall;
    logic [15:0] if_addr;
    logic [31:0] if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [15:0] dm_addr;
    logic [31:0] dm_wdata, dm_rdata;
    logic [3:0]  dm_wstrb;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_wstrb;
    logic [31:0] ram_rdata = '0;
    logic [31:0] perf_fetch_stall_cycles, perf_forced_fetch;
    logic [31:0] mem [1024];
    int vectors = 0;
    int miscompares = 0;

    mem_port_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .fetch_stall(fetch_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_wstrb(dm_wstrb), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb),
        .ram_rdata(ram_rdata),
        .perf_fetch_stall_cycles(perf_fetch_stall_cycles), .perf_forced_fetch(perf_forced_fetch)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int a);
        return {16'(a) ^ 16'hA5A5, 16'(a) + 16'h1234};
    endfunction

    always @(posedge clk) begin
        if (ram_we)
            for (int b = 0; b < 4; b++)
                if (ram_wstrb[b]) mem[ram_addr[11:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
        ram_rdata <= mem[ram_addr[11:2]];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] merged;
        for (int i = 0; i < 1024; i++) mem[i] = init_word(i * 4);
        reset_n = 0; if_req = 1; if_addr = 16'h0044;
        dm_req = 1; dm_we = 0; dm_addr = 16'h0100; dm_wdata = '0; dm_wstrb = '0;
        #2;
        check("rst_if_gnt", 64'(if_gnt), 0);
        check("rst_dm_gnt", 64'(dm_gnt), 0);
        check("rst_stall", 64'(fetch_stall), 0);
        check("rst_ram_addr", 64'(ram_addr), 0);
        check("rst_ram_we", 64'(ram_we), 0);
        tick; tick;
        check("rst_if_rvalid", 64'(if_rvalid), 0);
        check("rst_dm_rvalid", 64'(dm_rvalid), 0);
        check("rst_if_rdata", 64'(if_rdata), 0);
        check("rst_dm_rdata", 64'(dm_rdata), 0);
        reset_n = 1; if_req = 0; dm_req = 0;
        tick;

        for (int i = 0; i < 3; i++) begin
            if_req = 1; if_addr = 16'(4 * i);
            #1;
            check("fetch_gnt", 64'(if_gnt), 1);
            check("fetch_stall", 64'(fetch_stall), 0);
            check("fetch_ram_addr", 64'(ram_addr), 64'(4 * i));
            if (i > 0) begin
                check("fetch_rvalid", 64'(if_rvalid), 1);
                check("fetch_rdata", 64'(if_rdata), 64'(init_word(4 * (i - 1))));
            end
            tick;
        end
        if_req = 0;
        #1;
        check("fetch_rvalid_last", 64'(if_rvalid), 1);
        check("fetch_rdata_last", 64'(if_rdata), 64'(init_word(8)));
        tick;

        if_req = 1; if_addr = 16'h0010; dm_req = 1; dm_we = 0; dm_addr = 16'h0100;
        #1;
        check("conf_dm_gnt", 64'(dm_gnt), 1);
        check("conf_if_gnt", 64'(if_gnt), 0);
        check("conf_stall", 64'(fetch_stall), 1);
        check("conf_ram_addr", 64'(ram_addr), 64'h0100);
        tick;
        dm_req = 0;
        #1;
        check("conf_dm_rvalid", 64'(dm_rvalid), 1);
        check("conf_dm_rdata", 64'(dm_rdata), 64'(init_word(16'h0100)));
        check("conf_if_rdata_zero", 64'(if_rdata), 0);
        check("conf_if_gnt2", 64'(if_gnt), 1);
        tick;
        if_req = 0;
        #1;
        check("conf_if_rvalid", 64'(if_rvalid), 1);
        check("conf_if_rdata", 64'(if_rdata), 64'(init_word(16'h0010)));
        check("conf_dm_rvalid_off", 64'(dm_rvalid), 0);
        tick;

        dm_req = 1; dm_we = 0; dm_addr = 16'h0100;
        #1;
        check("mid_dm_gnt", 64'(dm_gnt), 1);
        reset_n = 0;
        #1;
        check("mid_rst_dm_gnt", 64'(dm_gnt), 0);
        check("mid_rst_ram_addr", 64'(ram_addr), 0);
        check("mid_rst_dm_rvalid", 64'(dm_rvalid), 0);
        tick;
        reset_n = 1; dm_req = 0;
        #1;
        check("mid_rel_dm_rvalid", 64'(dm_rvalid), 0);
        tick;
        check("mid_rel_dm_rvalid2", 64'(dm_rvalid), 0);
        check("mid_rel_if_rvalid", 64'(if_rvalid), 0);

        if_req = 1; if_addr = 16'h0020; dm_req = 1; dm_we = 0; dm_addr = 16'h0040;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("starve_dm_gnt", 64'(dm_gnt), 64'(k % 5 != 4));
            check("starve_if_gnt", 64'(if_gnt), 64'(k % 5 == 4));
            check("starve_stall", 64'(fetch_stall), 64'(k % 5 != 4));
            if (k % 5 == 0 && k > 0) begin
                check("starve_if_rvalid", 64'(if_rvalid), 1);
                check("starve_if_rdata", 64'(if_rdata), 64'(init_word(16'h0020)));
            end
            tick;
        end
`ifdef ARB_PERF_CNT_EN
        check("perf_stall", 64'(perf_fetch_stall_cycles), 8);
        check("perf_forced", 64'(perf_forced_fetch), 2);
`else
        check("perf_stall_tied", 64'(perf_fetch_stall_cycles), 0);
        check("perf_forced_tied", 64'(perf_forced_fetch), 0);
`endif
        if_req = 0; dm_req = 0;
        tick;

        if_req = 1; if_addr = 16'h0030;
        dm_req = 1; dm_we = 1; dm_addr = 16'h0200; dm_wdata = 32'hDEADBEEF; dm_wstrb = 4'b0011;
        #1;
        check("wr_dm_gnt", 64'(dm_gnt), 1);
        check("wr_ram_we", 64'(ram_we), 1);
        check("wr_ram_wstrb", 64'(ram_wstrb), 64'h3);
        check("wr_ram_wdata", 64'(ram_wdata), 64'hDEADBEEF);
        check("wr_ram_addr", 64'(ram_addr), 64'h0200);
        tick;
        dm_req = 0; dm_we = 0;
        #1;
        check("wr_ram_we_off", 64'(ram_we), 0);
        check("wr_ack", 64'(dm_rvalid), 1);
        check("wr_ack_rdata", 64'(dm_rdata), 0);
        check("wr_if_gnt", 64'(if_gnt), 1);
        tick;
        if_req = 0; dm_req = 1; dm_we = 0; dm_addr = 16'h0200;
        #1;
        check("rd_ram_wstrb", 64'(ram_wstrb), 0);
        check("rd_ram_we", 64'(ram_we), 0);
        tick;
        dm_req = 0;
        w = init_word(16'h0200);
        merged = {w[31:16], 16'hBEEF};
        #1;
        check("rd_merge_rvalid", 64'(dm_rvalid), 1);
        check("rd_merge_rdata", 64'(dm_rdata), 64'(merged));
        tick;

        dm_req = 1; dm_we = 1; dm_addr = 16'h0200; dm_wdata = 32'hFFFFFFFF; dm_wstrb = 4'b0000;
        #1;
        check("z_ram_we", 64'(ram_we), 1);
        check("z_ram_wstrb", 64'(ram_wstrb), 0);
        tick;
        dm_we = 0;
        #1;
        check("z_ack", 64'(dm_rvalid), 1);
        check("z_ack_rdata", 64'(dm_rdata), 0);
        tick;
        dm_req = 0;
        #1;
        check("z_readback", 64'(dm_rdata), 64'(merged));
        tick;

        if_req = 0; dm_req = 0; if_addr = 16'h1234;
        #1;
        check("idle_ram_addr", 64'(ram_addr), 64'h1234);
        check("idle_if_gnt", 64'(if_gnt), 0);
        check("idle_dm_gnt", 64'(dm_gnt), 0);
        check("idle_stall", 64'(fetch_stall), 0);
        tick;
        check("idle_rvalids", 64'({if_rvalid, dm_rvalid}), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
